// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage RV32 core (F, D, E, M, W).
// Combines load-use interlock, multi-cycle data-memory waits (fixed latency
// or ack-driven), multi-cycle execute ops and branch-redirect qualification
// into one set of pipeline-register enables and bubble inserts, plus a
// saturating count of front-end stall cycles.
module hazard_stall_ctrl #(
  parameter int MEM_LAT = 2,   // extra stall cycles per load in M (USE_ACK=0), 0..15
  parameter int USE_ACK = 0,   // 1: hold load in M until dmem_ack
  parameter int MC_LAT  = 4,   // cycles a multi-cycle op occupies E, 1..31
  parameter int CNT_W   = 32   // width of stall_cnt
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic [4:0]       rd_e,
  input  logic             regwrite_e,
  input  logic             memread_e,
  input  logic             memread_m,
  input  logic             mc_op_e,
  input  logic             pcsrc_e,
  input  logic             dmem_ack,
  output logic             en_pc,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             redirect,
  output logic             mem_busy,
  output logic             ex_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    M_IDLE,
    M_WAIT
  } mstate_e;

  typedef enum logic [1:0] {
    X_IDLE,
    X_BUSY,
    X_DONE
  } xstate_e;

  localparam bit         ACK_MODE  = (USE_ACK != 0);
  localparam bit         MEM_ZERO  = (MEM_LAT == 0);
  localparam bit         MC_MULTI  = (MC_LAT > 1);
  localparam logic [3:0] MEM_LAT_C = 4'(MEM_LAT);
  localparam logic [4:0] MC_LAST   = 5'(MC_LAT - 1);

  mstate_e          mstate_q, mstate_d;
  logic [3:0]       mcnt_q, mcnt_d;
  xstate_e          xstate_q, xstate_d;
  logic [4:0]       xcnt_q, xcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic mem_start;
  logic mem_stall;
  logic ex_stall;
  logic lw_hazard;
  logic en_mw_c;
  logic en_em_c;
  logic en_de_c;
  logic redirect_c;
  logic en_pc_c;

  // A load arriving in M needs a wait unless the latency is zero or the ack
  // is already present in the entry cycle.
  assign mem_start = memread_m & (ACK_MODE ? ~dmem_ack : ~MEM_ZERO);

  assign lw_hazard = memread_e & regwrite_e & (rd_e != 5'd0) &
                     ((rs1_used_d & (rs1_d == rd_e)) | (rs2_used_d & (rs2_d == rd_e)));

  // Stall priority chain: memory freezes everything from M back, execute
  // freezes E and earlier, load-use freezes D and earlier.
  assign en_mw_c    = ~mem_stall;
  assign en_em_c    = en_mw_c & ~ex_stall;
  assign redirect_c = pcsrc_e & en_em_c;
  assign en_de_c    = en_em_c & ~lw_hazard;
  assign en_pc_c    = en_de_c | redirect_c;

  // State register: both FSMs, their cycle counters and the stall counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstate_q <= M_IDLE;
      mcnt_q   <= '0;
      xstate_q <= X_IDLE;
      xcnt_q   <= '0;
      scnt_q   <= '0;
    end else begin
      mstate_q <= mstate_d;
      mcnt_q   <= mcnt_d;
      xstate_q <= xstate_d;
      xcnt_q   <= xcnt_d;
      scnt_q   <= scnt_d;
    end
  end

  // Memory FSM output: is the load in M still waiting this cycle.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mem_stall = 1'b0;
    case (mstate_q)
      M_IDLE:  mem_stall = mem_start;
      M_WAIT:  mem_stall = ACK_MODE ? ~dmem_ack : (mcnt_q < MEM_LAT_C);
      default: mem_stall = 1'b0;
    endcase
  end

  // Memory FSM next state: count wait cycles, release on latency or ack.
  always_comb begin
    mstate_d = mstate_q;
    mcnt_d   = mcnt_q;
    case (mstate_q)
      M_IDLE: begin
        if (mem_start) begin
          mstate_d = M_WAIT;
          mcnt_d   = 4'd1;
        end
      end
      M_WAIT: begin
        if (!mem_stall) begin
          mstate_d = M_IDLE;
          mcnt_d   = '0;
        end else if (!ACK_MODE) begin
          mcnt_d = mcnt_q + 4'd1;
        end
      end
      default: begin
        mstate_d = M_IDLE;
        mcnt_d   = '0;
      end
    endcase
  end

  // Execute FSM output: the multi-cycle op still needs E this cycle.
  always_comb begin
    ex_stall = 1'b0;
    case (xstate_q)
      X_IDLE:  ex_stall = mc_op_e & MC_MULTI;
      X_BUSY:  ex_stall = (xcnt_q < MC_LAST);
      default: ex_stall = 1'b0;
    endcase
  end

  // Execute FSM next state: X_DONE parks a finished op that a memory stall
  // keeps in E, so it does not start a second countdown.
  always_comb begin
    xstate_d = xstate_q;
    xcnt_d   = xcnt_q;
    case (xstate_q)
      X_IDLE: begin
        if (mc_op_e && MC_MULTI) begin
          xstate_d = X_BUSY;
          xcnt_d   = 5'd1;
        end
      end
      X_BUSY: begin
        if (ex_stall) begin
          xcnt_d = xcnt_q + 5'd1;
        end else begin
          xstate_d = en_em_c ? X_IDLE : X_DONE;
          xcnt_d   = '0;
        end
      end
      X_DONE: begin
        if (en_em_c) xstate_d = X_IDLE;
      end
      default: begin
        xstate_d = X_IDLE;
        xcnt_d   = '0;
      end
    endcase
  end

  // Stall counter next value: count frozen-PC cycles, saturate at all-ones.
  always_comb begin
    scnt_d = scnt_q;
    if (!en_pc_c && (scnt_q != '1)) scnt_d = scnt_q + CNT_W'(1);
  end

  // Outputs; while in reset the pipeline is opened and filled with bubbles.
  always_comb begin
    en_pc     = en_pc_c;
    en_fd     = en_de_c;
    en_de     = en_de_c;
    en_em     = en_em_c;
    en_mw     = en_mw_c;
    flush_d   = redirect_c;
    flush_e   = redirect_c | (lw_hazard & en_em_c);
    flush_w   = mem_stall;
    redirect  = redirect_c;
    mem_busy  = mem_stall;
    ex_busy   = ex_stall;
    stall_cnt = scnt_q;
    if (rst) begin
      en_pc     = 1'b1;
      en_fd     = 1'b1;
      en_de     = 1'b1;
      en_em     = 1'b1;
      en_mw     = 1'b1;
      flush_d   = 1'b1;
      flush_e   = 1'b1;
      flush_w   = 1'b1;
      redirect  = 1'b0;
      mem_busy  = 1'b0;
      ex_busy   = 1'b0;
      stall_cnt = '0;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three configurations share one input stream;
// a per-cycle model checks every instance, directed literals pin key points.
module tb_hazard_stall_ctrl;

  localparam int N = 3;
  // dut0: zero-latency memory, single-cycle execute, 2-bit counter
  // dut1: MEM_LAT=3, MC_LAT=4; dut2: ack-driven memory, MC_LAT=4
  localparam int ML[N] = '{0, 3, 2};
  localparam int UA[N] = '{0, 0, 1};
  localparam int XL[N] = '{1, 4, 4};
  localparam int CW[N] = '{2, 32, 8};

  // bit positions inside the packed output vector
  localparam int B_EN_PC = 10, B_EN_FD = 9, B_EN_DE = 8, B_EN_EM = 7, B_EN_MW = 6;
  localparam int B_FL_D = 5, B_FL_E = 4, B_FL_W = 3, B_REDIR = 2, B_MBUSY = 1, B_XBUSY = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic       rs1_used_d, rs2_used_d, regwrite_e, memread_e, memread_m;
  logic       mc_op_e, pcsrc_e, dmem_ack;

  logic [10:0] outv[N];
  logic [31:0] cntv[N];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic en_pc, en_fd, en_de, en_em, en_mw;
    logic flush_d, flush_e, flush_w, redirect, mem_busy, ex_busy;
    logic [CW[g]-1:0] sc;

    hazard_stall_ctrl #(
      .MEM_LAT(ML[g]), .USE_ACK(UA[g]), .MC_LAT(XL[g]), .CNT_W(CW[g])
    ) u_dut (
      .clk(clk), .rst(rst),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
      .rd_e(rd_e), .regwrite_e(regwrite_e), .memread_e(memread_e), .memread_m(memread_m),
      .mc_op_e(mc_op_e), .pcsrc_e(pcsrc_e), .dmem_ack(dmem_ack),
      .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
      .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w), .redirect(redirect),
      .mem_busy(mem_busy), .ex_busy(ex_busy), .stall_cnt(sc)
    );

    assign outv[g] = {en_pc, en_fd, en_de, en_em, en_mw,
                      flush_d, flush_e, flush_w, redirect, mem_busy, ex_busy};
    assign cntv[g] = 32'(sc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic lit(input string name, input int i, input int b, input bit exp);
    check($sformatf("%s dut%0d", name, i), 32'(outv[i][b]), 32'(exp));
  endtask

  task automatic lit_cnt(input string name, input int i, input int exp);
    check($sformatf("%s dut%0d stall_cnt", name, i), cntv[i], 32'(exp));
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: each wait is tracked by how long it has been going,
  // outputs follow from the enable/flush rules.
  // ---------------------------------------------------------------------
  bit     m_pend[N];
  int     m_age[N];
  bit     x_act[N];
  int     x_age[N];
  longint m_cnt[N];

  always @(negedge clk) begin
    bit ms, xs, lw, enmw, enem, rdr, ende, enpc;
    logic [10:0] ev;
    logic [31:0] ec;
    longint cmax;
    for (int i = 0; i < N; i++) begin
      lw = memread_e && regwrite_e && (rd_e != 5'd0) &&
           ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));
      ms = (m_pend[i] || memread_m) &&
           ((UA[i] != 0) ? !dmem_ack : (m_age[i] < ML[i]));
      xs = (x_act[i] || mc_op_e) && (x_age[i] < XL[i] - 1);
      enmw = !ms;
      enem = enmw && !xs;
      rdr  = pcsrc_e && enem;
      ende = enem && !lw;
      enpc = ende || rdr;
      if (rst) begin
        ev = 11'h7F8;
        ec = 32'd0;
      end else begin
        ev = {enpc, ende, ende, enem, enmw, rdr, rdr || (lw && enem), ms, rdr, ms, xs};
        ec = 32'(m_cnt[i]);
      end
      check($sformatf("cyc%0d dut%0d outputs", cyc, i), 32'(outv[i]), 32'(ev));
      check($sformatf("cyc%0d dut%0d stall_cnt", cyc, i), cntv[i], ec);
      cmax = (64'd1 << CW[i]) - 1;
      if (rst) begin
        m_pend[i] = 1'b0; m_age[i] = 0; x_act[i] = 1'b0; x_age[i] = 0; m_cnt[i] = 0;
      end else begin
        if (ms) begin m_pend[i] = 1'b1; m_age[i]++; end
        else begin m_pend[i] = 1'b0; m_age[i] = 0; end
        if (xs) begin x_act[i] = 1'b1; x_age[i]++; end
        else if (x_act[i] && enem) begin x_act[i] = 1'b0; x_age[i] = 0; end
        if (!enpc && m_cnt[i] < cmax) m_cnt[i]++;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  task automatic clear_in();
    rs1_d = '0; rs2_d = '0; rd_e = '0;
    rs1_used_d = 1'b0; rs2_used_d = 1'b0; regwrite_e = 1'b0; memread_e = 1'b0;
    memread_m = 1'b0; mc_op_e = 1'b0; pcsrc_e = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // one reset edge with idle inputs, returns at start of scenario cycle 0
  task automatic start();
    clear_in();
    rst = 1'b1;
    next();
    rst = 1'b0;
  endtask

  task automatic hazard_x5();
    memread_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5;
    rs1_d = 5'd5; rs1_used_d = 1'b1; rs2_d = 5'd1; rs2_used_d = 1'b1;
  endtask

  typedef struct {
    logic [4:0] rd, rs1, rs2;
    bit regw, memr, u1, u2, exp_en_de;
  } hz_vec_t;

  hz_vec_t hz_tab[6] = '{
    '{rd: 5'd7, rs1: 5'd3, rs2: 5'd7, regw: 1, memr: 1, u1: 1, u2: 1, exp_en_de: 0},
    '{rd: 5'd0, rs1: 5'd0, rs2: 5'd0, regw: 1, memr: 1, u1: 1, u2: 1, exp_en_de: 1},
    '{rd: 5'd9, rs1: 5'd9, rs2: 5'd2, regw: 1, memr: 1, u1: 0, u2: 1, exp_en_de: 1},
    '{rd: 5'd9, rs1: 5'd9, rs2: 5'd2, regw: 0, memr: 1, u1: 1, u2: 1, exp_en_de: 1},
    '{rd: 5'd9, rs1: 5'd9, rs2: 5'd2, regw: 1, memr: 0, u1: 1, u2: 1, exp_en_de: 1},
    '{rd: 5'd4, rs1: 5'd1, rs2: 5'd4, regw: 1, memr: 1, u1: 1, u2: 0, exp_en_de: 1}
  };

  initial begin
    clear_in();
    rst = 1'b1;

    // Reset with every hazard source active
    memread_m = 1'b1; mc_op_e = 1'b1; pcsrc_e = 1'b1; hazard_x5();
    @(negedge clk);
    check("reset outputs dut1", 32'(outv[1]), 32'h7F8);
    lit_cnt("reset", 1, 0);
    next();

    // Load-use, zero memory latency
    start();
    hazard_x5();
    @(negedge clk);
    lit("lu en_pc", 0, B_EN_PC, 0);
    lit("lu en_fd", 0, B_EN_FD, 0);
    lit("lu en_de", 0, B_EN_DE, 0);
    lit("lu en_em", 0, B_EN_EM, 1);
    lit("lu flush_e", 0, B_FL_E, 1);
    next();
    memread_e = 1'b0; regwrite_e = 1'b0; rd_e = 5'd0; memread_m = 1'b1;
    @(negedge clk);
    lit("lu issue en_pc", 0, B_EN_PC, 1);
    lit("lu issue flush_e", 0, B_FL_E, 0);
    lit_cnt("lu", 0, 1);
    next();

    // Hazard decode corner cases
    for (int k = 0; k < 6; k++) begin
      start();
      rd_e = hz_tab[k].rd; rs1_d = hz_tab[k].rs1; rs2_d = hz_tab[k].rs2;
      regwrite_e = hz_tab[k].regw; memread_e = hz_tab[k].memr;
      rs1_used_d = hz_tab[k].u1; rs2_used_d = hz_tab[k].u2;
      @(negedge clk);
      lit($sformatf("hz%0d en_de", k), 0, B_EN_DE, hz_tab[k].exp_en_de);
      next();
    end

    // Stall counter saturation on the 2-bit instance
    start();
    hazard_x5();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 3) lit_cnt("sat", 0, 3);
      next();
    end
    clear_in();
    @(negedge clk);
    lit_cnt("sat hold", 0, 3);
    next();

    // Fixed-latency load, MEM_LAT=3, with a load-use hazard arriving mid-wait
    start();
    memread_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) hazard_x5();
      @(negedge clk);
      if (k < 3) begin
        lit($sformatf("mem%0d busy", k), 1, B_MBUSY, 1);
        lit($sformatf("mem%0d en_mw", k), 1, B_EN_MW, 0);
        lit($sformatf("mem%0d flush_w", k), 1, B_FL_W, 1);
      end
      if (k == 1) begin
        lit("mem lw flush_e", 1, B_FL_E, 0);
        lit("mem lw en_de", 1, B_EN_DE, 0);
      end
      if (k == 3) begin
        lit("mem rel en_mw", 1, B_EN_MW, 1);
        lit("mem rel busy", 1, B_MBUSY, 0);
        lit("mem rel flush_e", 1, B_FL_E, 1);
        lit_cnt("mem", 1, 3);
      end
      next();
    end

    // Ack-driven load: ack 5 cycles after entry, then ack in the entry cycle
    start();
    memread_m = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lit($sformatf("ack%0d busy", k), 2, B_MBUSY, 1);
      next();
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    lit("ack rel busy", 2, B_MBUSY, 0);
    lit("ack rel en_mw", 2, B_EN_MW, 1);
    lit_cnt("ack", 2, 5);
    next();
    clear_in();
    next();
    memread_m = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    lit("ack entry busy", 2, B_MBUSY, 0);
    lit("ack entry en_pc", 2, B_EN_PC, 1);
    next();
    clear_in();
    @(negedge clk);
    lit_cnt("ack entry", 2, 5);
    next();

    // Multi-cycle op overlapped by a 3-cycle memory stall one cycle later
    start();
    mc_op_e = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) memread_m = 1'b1;
      if (k == 5) clear_in();
      @(negedge clk);
      case (k)
        0: begin lit("ov0 ex", 1, B_XBUSY, 1); lit("ov0 mem", 1, B_MBUSY, 0); end
        2: begin lit("ov2 ex", 1, B_XBUSY, 1); lit("ov2 mem", 1, B_MBUSY, 1); end
        3: begin
          lit("ov3 ex", 1, B_XBUSY, 0); lit("ov3 mem", 1, B_MBUSY, 1);
          lit("ov3 en_em", 1, B_EN_EM, 0); lit("ov3 en_pc", 1, B_EN_PC, 0);
        end
        4: begin
          lit("ov4 ex", 1, B_XBUSY, 0); lit("ov4 en_em", 1, B_EN_EM, 1);
          lit("ov4 en_pc", 1, B_EN_PC, 1); lit_cnt("ov", 1, 4);
        end
        5: lit("ov5 ex", 1, B_XBUSY, 0);
        default: ;
      endcase
      next();
    end

    // Taken branch held in E behind a multi-cycle op
    start();
    mc_op_e = 1'b1; pcsrc_e = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) clear_in();
      @(negedge clk);
      if (k < 3) begin
        lit($sformatf("br%0d redirect", k), 1, B_REDIR, 0);
        lit($sformatf("br%0d flush_d", k), 1, B_FL_D, 0);
      end else if (k == 3) begin
        lit("br redirect", 1, B_REDIR, 1);
        lit("br flush_d", 1, B_FL_D, 1);
        lit("br flush_e", 1, B_FL_E, 1);
        lit("br en_pc", 1, B_EN_PC, 1);
      end else begin
        lit("br after redirect", 1, B_REDIR, 0);
      end
      next();
    end

    // Reset asserted in the middle of a memory wait
    start();
    memread_m = 1'b1;
    @(negedge clk);
    next();
    @(negedge clk);
    lit("rw busy", 1, B_MBUSY, 1);
    next();
    rst = 1'b1; pcsrc_e = 1'b1; hazard_x5();
    @(negedge clk);
    check("rw reset outputs dut1", 32'(outv[1]), 32'h7F8);
    lit_cnt("rw reset", 1, 0);
    next();
    rst = 1'b0;
    clear_in();
    @(negedge clk);
    lit("rw idle busy", 1, B_MBUSY, 0);
    lit("rw idle en_pc", 1, B_EN_PC, 1);
    lit_cnt("rw idle", 1, 0);
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
